// File: rtl/spi_slave.sv
// spi_slave - SPI slave with an asynchronous serial interface and a single
// word-wide TX holding register.
//
// SCK, SS and MOSI are brought into the clk domain through two-flop
// synchronizers. All serial timing is derived from the synchronized SCK, so
// SCK high and low phases must each last at least four clk periods.
//
// Ports
//   clk          system clock, rising edge
//   n_rst        synchronous active-low reset
//   SCK          serial clock from the master (asynchronous)
//   SS           slave select, active-low (asynchronous)
//   MOSI         serial data from the master
//   MISO         serial data to the master, high-Z while deselected
//   data_in      next word to transmit
//   load_in      write data_in into the holding register (when ready_out=1)
//   ready_out    holding register empty
//   data_out     last complete received word
//   valid_out    one-clk pulse, data_out has just been updated
//   tx_underrun  one-clk pulse, a word started with an empty holding register
//   busy         slave is selected (ACTIVE)
module spi_slave #(
  parameter int DATA_BITS = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 1,
  parameter int LSBF      = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 SCK,
  input  logic                 SS,
  input  logic                 MOSI,
  output logic                 MISO,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load_in,
  output logic                 ready_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 tx_underrun,
  output logic                 busy
);

  localparam int              CNT_W  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic            CPOL_B = (CPOL != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Bit that goes on the wire first from a word.
  function automatic logic out_bit(input logic [DATA_BITS-1:0] w);
    return (LSBF != 0) ? w[0] : w[DATA_BITS-1];
  endfunction

  // Drop the bit just sent, zero fill.
  function automatic logic [DATA_BITS-1:0] shift_out(input logic [DATA_BITS-1:0] w);
    return (LSBF != 0) ? {1'b0, w[DATA_BITS-1:1]} : {w[DATA_BITS-2:0], 1'b0};
  endfunction

  // Insert a received bit so that a full word ends up in natural order.
  function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] w,
                                                    input logic              b);
    return (LSBF != 0) ? {b, w[DATA_BITS-1:1]} : {w[DATA_BITS-2:0], b};
  endfunction

  // Synchronizers: [0],[1] are the two-flop chain, [2] is the previous
  // synchronized value used for edge detection.
  logic [2:0]           sck_sync_q, sck_sync_d;
  logic [2:0]           ss_sync_q,  ss_sync_d;
  logic [1:0]           mosi_sync_q, mosi_sync_d;

  state_t               state_q,     state_d;
  logic [CNT_W-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] tx_sr_q,     tx_sr_d;
  logic [DATA_BITS-1:0] rx_sr_q,     rx_sr_d;
  logic                 miso_q,      miso_d;
  logic [DATA_BITS-1:0] hold_q,      hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] data_out_q,  data_out_d;
  logic                 valid_q,     valid_d;
  logic                 underrun_q,  underrun_d;

  logic                 sck_now, sck_prev, ss_now, ss_prev, mosi_s;
  logic                 lead_edge, trail_edge, sample_edge, shift_edge;
  logic                 ss_fall, ss_rise;
  logic                 word_start;
  logic [DATA_BITS-1:0] tx_word;

  always_comb begin
    sck_now     = sck_sync_q[1];
    sck_prev    = sck_sync_q[2];
    ss_now      = ss_sync_q[1];
    ss_prev     = ss_sync_q[2];
    mosi_s      = mosi_sync_q[1];

    lead_edge   = (sck_now != CPOL_B) && (sck_prev == CPOL_B);
    trail_edge  = (sck_now == CPOL_B) && (sck_prev != CPOL_B);
    sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    shift_edge  = (CPHA != 0) ? lead_edge  : trail_edge;
    ss_fall     = !ss_now &&  ss_prev;
    ss_rise     =  ss_now && !ss_prev;
  end

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], SCK};
    ss_sync_d   = {ss_sync_q[1:0], SS};
    mosi_sync_d = {mosi_sync_q[0], MOSI};

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    miso_d      = miso_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    underrun_d  = 1'b0;
    word_start  = 1'b0;
    tx_word     = '0;

    case (state_q)
      IDLE: begin
        // SCK activity is ignored until selected.
        if (ss_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          word_start = 1'b1;
        end
      end

      ACTIVE: begin
        if (ss_rise) begin
          // Deselect, possibly mid-word: drop the partial word silently.
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          if (sample_edge) begin
            rx_sr_d = shift_in(rx_sr_q, mosi_s);
            if (bit_cnt_q == LAST) begin
              bit_cnt_d  = '0;
              data_out_d = rx_sr_d;
              valid_d    = 1'b1;
              // With CPHA=1 the last sample is the last edge of the word.
              if (CPHA != 0) word_start = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (shift_edge) begin
            // With CPHA=0 the trailing edge after the final sample closes the
            // word; it loads the next word instead of shifting.
            if ((CPHA == 0) && (bit_cnt_q == '0)) begin
              word_start = 1'b1;
            end else begin
              miso_d  = out_bit(tx_sr_q);
              tx_sr_d = shift_out(tx_sr_q);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (word_start) begin
      if (hold_full_q) begin
        tx_word = hold_q;
      end else begin
        tx_word    = '0;
        underrun_d = 1'b1;
      end
      hold_full_d = 1'b0;
      // CPHA=0 must have the first bit on MISO before the first edge;
      // CPHA=1 puts it out on the first leading edge.
      if (CPHA == 0) begin
        miso_d  = out_bit(tx_word);
        tx_sr_d = shift_out(tx_word);
      end else begin
        tx_sr_d = tx_word;
      end
    end

    // A load landing in the same clk as a word start refills the register
    // that is being emptied.
    if (load_in && (!hold_full_q || word_start)) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sck_sync_q  <= {3{CPOL_B}};
      // SS chain starts "selected" so a master already holding SS low across
      // reset does not produce a fall; a fresh SS fall is needed to restart.
      ss_sync_q   <= 3'b000;
      mosi_sync_q <= 2'b00;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      miso_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      miso_q      <= miso_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign MISO        = busy ? miso_q : 1'bz;
  assign ready_out   = !hold_full_q;
  assign data_out    = data_out_q;
  assign valid_out   = valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: eight instances cover every CPOL/CPHA/LSBF
// combination (index bit0=CPOL, bit1=CPHA, bit2=LSBF). Instance 2 is the
// default configuration (CPOL=0, CPHA=1, MSB first).
module tb_spi_slave;

  localparam int H = 8;  // SCK half period in clk cycles

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] sck;
  logic [7:0] ss;
  logic [7:0] mosi;
  wire  [7:0] miso;
  logic [7:0] load_in;
  logic [7:0] ready;
  logic [7:0] valid;
  logic [7:0] unr;
  logic [7:0] busy;
  logic [7:0] data_in [8];
  logic [7:0] dout    [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_dut
    spi_slave #(
      .DATA_BITS(8),
      .CPOL(g % 2),
      .CPHA((g / 2) % 2),
      .LSBF(g / 4)
    ) u_dut (
      .clk(clk),
      .n_rst(n_rst),
      .SCK(sck[g]),
      .SS(ss[g]),
      .MOSI(mosi[g]),
      .MISO(miso[g]),
      .data_in(data_in[g]),
      .load_in(load_in[g]),
      .ready_out(ready[g]),
      .data_out(dout[g]),
      .valid_out(valid[g]),
      .tx_underrun(unr[g]),
      .busy(busy[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters observed from the DUTs.
  int vcnt [8] = '{default: 0};
  int ucnt [8] = '{default: 0};

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (valid[k]) vcnt[k] <= vcnt[k] + 1;
      if (unr[k])   ucnt[k] <= ucnt[k] + 1;
    end
  end

  // Reference model: one holding slot per slave, the word being sent, and
  // the pulse counts that should have been seen.
  logic       hold_full_m [8];
  logic [7:0] hold_m      [8];
  logic [7:0] cur_tx      [8];
  int         exp_valid   [8];
  int         exp_unr     [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A new word begins: the slave takes the holding word or sends zeros.
  task automatic model_start(input int k);
    if (hold_full_m[k]) begin
      cur_tx[k]      = hold_m[k];
      hold_full_m[k] = 1'b0;
    end else begin
      cur_tx[k]  = 8'h00;
      exp_unr[k] = exp_unr[k] + 1;
    end
  endtask

  task automatic ld(input int k, input logic [7:0] v);
    int t;
    t = 0;
    while (!ready[k] && t < 50) begin
      wclk(1);
      t++;
    end
    chk("load_ready", ready[k], !hold_full_m[k]);
    data_in[k] = v;
    load_in[k] = 1'b1;
    wclk(1);
    load_in[k]     = 1'b0;
    hold_m[k]      = v;
    hold_full_m[k] = 1'b1;
  endtask

  // Master side of nb bits of a word on slave k.
  task automatic xfer(input int k, input logic [7:0] tx, input int nb, output logic [7:0] rx);
    logic cpol, cpha, lsbf;
    int   b;
    cpol = ((k % 2) == 1);
    cpha = (((k / 2) % 2) == 1);
    lsbf = (k >= 4);
    rx   = 8'h00;
    for (int i = 0; i < nb; i++) begin
      b = lsbf ? i : 7 - i;
      if (!cpha) begin
        mosi[k] = tx[b];
        wclk(H);
        rx[b]   = miso[k];
        sck[k]  = ~cpol;
        wclk(H);
        sck[k]  = cpol;
      end else begin
        sck[k]  = ~cpol;
        mosi[k] = tx[b];
        wclk(H);
        rx[b]   = miso[k];
        sck[k]  = cpol;
        wclk(H);
      end
    end
    wclk(H);
  endtask

  task automatic ss_low(input int k);
    ss[k] = 1'b0;
    model_start(k);
    wclk(10);
  endtask

  task automatic ss_high(input int k);
    wclk(4);
    ss[k] = 1'b1;
    wclk(10);
  endtask

  // One full word; the completion starts the next word in the model.
  task automatic word(input int k, input logic [7:0] mw);
    logic [7:0] rx;
    xfer(k, mw, 8, rx);
    chk("master_rx", rx, cur_tx[k]);
    exp_valid[k] = exp_valid[k] + 1;
    chk("data_out", dout[k], mw);
    model_start(k);
  endtask

  task automatic counts(input int k);
    chk("valid_count", vcnt[k], exp_valid[k]);
    chk("underrun_count", ucnt[k], exp_unr[k]);
  endtask

  initial begin
    logic [7:0] rxd;
    int         ub, vb, k, nw;

    n_rst   = 1'b0;
    sck     = 8'b1010_1010;
    ss      = 8'hFF;
    mosi    = 8'h00;
    load_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      data_in[i]     = 8'h00;
      hold_full_m[i] = 1'b0;
      hold_m[i]      = 8'h00;
      cur_tx[i]      = 8'h00;
      exp_valid[i]   = 0;
      exp_unr[i]     = 0;
    end
    wclk(3);

    // Reset values
    for (int i = 0; i < 8; i++) begin
      chk("rst_ready", ready[i], 1'b1);
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_data_out", dout[i], 8'h00);
      chk("rst_valid", valid[i], 1'b0);
      chk("rst_underrun", unr[i], 1'b0);
    end

    // Load on the first clk after reset release
    n_rst       = 1'b1;
    data_in[2]  = 8'hAA;
    load_in[2]  = 1'b1;
    wclk(1);
    load_in[2]     = 1'b0;
    hold_m[2]      = 8'hAA;
    hold_full_m[2] = 1'b1;
    chk("ready_after_release_load", ready[2], 1'b0);
    chk("ready_after_release_noload", ready[0], 1'b1);

    // Single word: preload 0xAA, master sends 0xFA
    vb = vcnt[2];
    ss_low(2);
    word(2, 8'hFA);
    ss_high(2);
    chk("single_valid_pulses", vcnt[2] - vb, 1);
    counts(2);

    // Four words back to back under one SS low
    ub = ucnt[2];
    ld(2, 8'hAA);
    ss_low(2);
    ld(2, 8'hBB);
    word(2, 8'hFA);
    ld(2, 8'hCC);
    word(2, 8'hFB);
    ld(2, 8'hDD);
    word(2, 8'hFC);
    ld(2, 8'h00);
    word(2, 8'hFE);
    ss_high(2);
    chk("burst_no_underrun", ucnt[2] - ub, 0);
    counts(2);

    // Abort after 3 bits, holding register kept, then a full word 0x3C
    ss_low(2);
    ld(2, 8'h77);
    vb = vcnt[2];
    xfer(2, 8'h3C, 3, rxd);
    ss_high(2);
    chk("abort_no_valid", vcnt[2] - vb, 0);
    chk("abort_data_out_kept", dout[2], 8'hFE);
    chk("abort_ready_kept", ready[2], 1'b0);
    ss_low(2);
    word(2, 8'h3C);
    ss_high(2);
    counts(2);

    // No load before SS falls: one underrun, master sees 0x00
    ub = ucnt[2];
    ss_low(2);
    ld(2, 8'h11);
    word(2, 8'h5A);
    ss_high(2);
    chk("underrun_once", ucnt[2] - ub, 1);
    counts(2);

    // Reset for 2 clk in the middle of a word
    ss_low(2);
    xfer(2, 8'h99, 4, rxd);
    vb    = vcnt[2];
    n_rst = 1'b0;
    wclk(2);
    chk("midrst_ready", ready[2], 1'b1);
    chk("midrst_busy", busy[2], 1'b0);
    chk("midrst_data_out", dout[2], 8'h00);
    chk("midrst_valid", valid[2], 1'b0);
    chk("midrst_underrun", unr[2], 1'b0);
    n_rst = 1'b1;
    for (int i = 0; i < 8; i++) hold_full_m[i] = 1'b0;
    wclk(10);
    chk("midrst_no_restart", busy[2], 1'b0);
    ss[2] = 1'b1;
    wclk(10);
    chk("midrst_no_valid", vcnt[2] - vb, 0);
    ld(2, 8'h42);
    ss_low(2);
    word(2, 8'h81);
    ss_high(2);
    counts(2);

    // Every mode and bit order: 0x01 / 0x80 exchanged both ways
    for (int i = 0; i < 8; i++) begin
      ld(i, 8'h80);
      ss_low(i);
      ld(i, 8'h01);
      word(i, 8'h01);
      word(i, 8'h80);
      ss_high(i);
      counts(i);
    end

    // Random words on random configurations
    for (int r = 0; r < 16; r++) begin
      k  = $urandom_range(7, 0);
      nw = $urandom_range(3, 1);
      if (!hold_full_m[k] && ($urandom_range(1, 0) == 1)) ld(k, 8'($urandom));
      ss_low(k);
      for (int w = 0; w < nw; w++) begin
        if (!hold_full_m[k] && ($urandom_range(3, 0) != 0)) ld(k, 8'($urandom));
        word(k, 8'($urandom));
      end
      ss_high(k);
      counts(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
